// File: rtl/cva6_banked_regfile.sv
// cva6_banked_regfile: flip-flop integer register file with a stack of shadow banks for
// nested interrupt entry/exit. A save pushes the masked GPRs and drops sp (x2) by one frame;
// a restore pops them and raises sp.
// Optional build macro: CVA6_SHADOW_CSR_EN also stacks mepc/mcause alongside the GPRs.
module cva6_banked_regfile #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NR_READ_PORTS  = 2,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned NR_BANKS       = 4,
  parameter logic [31:0] SAVE_MASK      = 32'hF003FCE2,
  parameter bit          ZERO_REG_ZERO  = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NR_READ_PORTS*ADDR_WIDTH-1:0]     raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]     rdata_o,
  input  logic [NR_WRITE_PORTS*ADDR_WIDTH-1:0]    waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]               we_i,
  input  logic                                    save_i,
  input  logic                                    restore_i,
  output logic [$clog2(NR_BANKS+1)-1:0]           depth_o,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic [DATA_WIDTH-1:0]                   sp_o,
  output logic [DATA_WIDTH-1:0]                   next_sp_o,
`ifdef CVA6_SHADOW_CSR_EN
  input  logic [DATA_WIDTH-1:0]                   mepc_i,
  input  logic [DATA_WIDTH-1:0]                   mcause_i,
  output logic [DATA_WIDTH-1:0]                   mepc_o,
  output logic [DATA_WIDTH-1:0]                   mcause_o,
`endif
  output logic                                    err_o
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;

  // x0 and x2 are never stacked; x2 is handled arithmetically instead
  function automatic bit is_saved(input int unsigned i);
    return (i < NUM_WORDS) && (i != 0) && (i != 2) && (((SAVE_MASK >> i) & 32'd1) != 32'd0);
  endfunction

  function automatic int unsigned count_saved();
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) if (is_saved(i)) n++;
    return n;
  endfunction

  // Register index held in bank slot k
  function automatic int unsigned slot_reg(input int unsigned k);
    int unsigned n, r;
    n = 0;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (is_saved(i)) begin
        if (n == k) r = i;
        n++;
      end
    end
    return r;
  endfunction

  localparam int unsigned NR_SAVED = count_saved();
  localparam int unsigned DEPTH_W  = $clog2(NR_BANKS + 1);
  localparam int unsigned BANK_W   = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1;
  localparam int unsigned SLOT_W   = (NR_SAVED > 1) ? $clog2(NR_SAVED) : 1;
  localparam int unsigned WP_W     = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;
  localparam logic [DATA_WIDTH-1:0] FRAME_BYTES = DATA_WIDTH'(NR_SAVED * DATA_WIDTH / 8);

  logic [DATA_WIDTH-1:0] regs_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_WORDS];
  logic [DATA_WIDTH-1:0] bank_q [NR_BANKS][NR_SAVED];
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  err_q, err_d;
  logic                  full, empty, push, pop;
  logic [BANK_W-1:0]     push_idx, pop_idx;
  logic [ADDR_WIDTH-1:0] waddr_w [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata_w [NR_WRITE_PORTS];

  assign full     = (depth_q == DEPTH_W'(NR_BANKS));
  assign empty    = (depth_q == '0);
  assign push     = save_i & ~restore_i & ~full;
  assign pop      = restore_i & ~save_i & ~empty;
  assign err_d    = (save_i & restore_i) | (save_i & full) | (restore_i & empty);
  assign push_idx = BANK_W'(depth_q);
  assign pop_idx  = BANK_W'(depth_q - DEPTH_W'(1));

  assign depth_o   = depth_q;
  assign full_o    = full;
  assign empty_o   = empty;
  assign err_o     = err_q;
  assign sp_o      = regs_q[2];
  assign next_sp_o = rst_i ? '0 : regs_d[2];

  // Unpack write ports into per-port arrays
  for (genvar g = 0; g < NR_WRITE_PORTS; g++) begin : g_wp
    assign waddr_w[g] = waddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_w[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Combinational read ports, no write bypass
  for (genvar g = 0; g < NR_READ_PORTS; g++) begin : g_rp
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rdata_o[g*DATA_WIDTH +: DATA_WIDTH] = (ZERO_REG_ZERO && (ra == '0)) ? '0 : regs_q[ra];
  end

  // Next register state: writes (highest port wins), then pop overrides, then sp adjust
  always_comb begin
    regs_d  = regs_q;
    depth_d = depth_q;
    for (int unsigned wp = 0; wp < NR_WRITE_PORTS; wp++) begin
      if (we_i[WP_W'(wp)]) regs_d[waddr_w[WP_W'(wp)]] = wdata_w[WP_W'(wp)];
    end
    if (push) begin
      regs_d[2] = regs_d[2] - FRAME_BYTES;
      depth_d   = depth_q + DEPTH_W'(1);
    end else if (pop) begin
      for (int unsigned k = 0; k < NR_SAVED; k++) begin
        regs_d[ADDR_WIDTH'(slot_reg(k))] = bank_q[pop_idx][SLOT_W'(k)];
      end
      regs_d[2] = regs_d[2] + FRAME_BYTES;
      depth_d   = depth_q - DEPTH_W'(1);
    end
    if (ZERO_REG_ZERO) regs_d[0] = '0;
  end

  // State update; a push snapshots the pre-edge register values
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q  <= '{default: '0};
      bank_q  <= '{default: '{default: '0}};
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      if (push) begin
        for (int unsigned k = 0; k < NR_SAVED; k++) begin
          bank_q[push_idx][SLOT_W'(k)] <= regs_q[ADDR_WIDTH'(slot_reg(k))];
        end
      end
    end
  end

`ifdef CVA6_SHADOW_CSR_EN
  logic [DATA_WIDTH-1:0] mepc_bank_q   [NR_BANKS];
  logic [DATA_WIDTH-1:0] mcause_bank_q [NR_BANKS];

  assign mepc_o   = empty ? '0 : mepc_bank_q[pop_idx];
  assign mcause_o = empty ? '0 : mcause_bank_q[pop_idx];

  // Trap CSRs stacked alongside the GPR frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mepc_bank_q   <= '{default: '0};
      mcause_bank_q <= '{default: '0};
    end else if (push) begin
      mepc_bank_q[push_idx]   <= mepc_i;
      mcause_bank_q[push_idx] <= mcause_i;
    end
  end
`endif

endmodule
